// File: rtl/placement_pkg.sv
// Shared definitions for the placement engine and its grid read-back checker:
// FSM encoding, the empty-cell marker, default geometry and the record payload.
package placement_pkg;

  localparam int unsigned W            = 32;
  localparam int unsigned DEF_N        = 9;
  localparam int unsigned DEF_NODE_CNT = 11;

  localparam logic [W-1:0] EMPTY_CELL = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_G_RD,
    S_G_CHK,
    S_P_RD,
    S_P_CHK,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_e;

  // One read-back record per occupied cell.
  typedef struct packed {
    logic [W-1:0] node;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         err;
  } rec_t;

endpackage

// File: rtl/placement_grid_reader_if.sv
// Record stream from the grid reader: valid/ready handshake plus
// (node, x, y, err) payload. master = producer, slave = consumer.
interface placement_grid_reader_if;
  import placement_pkg::*;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_node;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;
  logic         out_err;

  modport master (
    output out_valid, out_node, out_x, out_y, out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_node, out_x, out_y, out_err,
    output out_ready
  );

endinterface

// File: rtl/grid_scan_counter.sv
// Row-major x/y walker over an N*N grid.
//   clr    : restart at cell (0,0)
//   inc    : advance one cell (y fastest)
//   x, y   : current cell coordinates
//   addr   : x*N+y of the current cell, registered alongside x/y
//   last_c : current cell is (N-1, N-1)
module grid_scan_counter
  import placement_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] addr,
  output logic         last_c
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W-1:0] SIDE     = W'(N);

  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] addr_q, addr_d;

  // Next coordinates; the address tracks them so it is ready in the same cycle.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      if (y_q == LAST_IDX) begin
        y_d = '0;
        x_d = x_q + W'(1);
      end else begin
        y_d = y_q + W'(1);
      end
    end
    addr_d = (x_d * SIDE) + y_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign addr   = addr_q;
  assign last_c = (x_q == LAST_IDX) && (y_q == LAST_IDX);

endmodule

// File: rtl/placement_grid_reader.sv
// Post-placement read-back checker. Walks the grid RAM row-major, skips empty
// cells, reads pos_X/pos_Y for each occupied cell and streams one
// (node, x, y, err) record per occupied cell.
//   start/busy/done          : scan control
//   grid_*, px_*, py_*       : synchronous-read RAM ports (read only)
//   out_if                   : record stream (master side)
//   cell_count/mismatch_count: totals for the current/last scan
module placement_grid_reader
  import placement_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned NODE_CNT = DEF_NODE_CNT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            grid_re,
  output logic [W-1:0]                    grid_addr,
  input  logic [W-1:0]                    grid_dout,
  output logic                            px_re,
  output logic [W-1:0]                    px_addr,
  input  logic [W-1:0]                    px_dout,
  output logic                            py_re,
  output logic [W-1:0]                    py_addr,
  input  logic [W-1:0]                    py_dout,
  placement_grid_reader_if.master         out_if,
  output logic [W-1:0]                    cell_count,
  output logic [W-1:0]                    mismatch_count
);

  localparam logic [W-1:0] ID_LIMIT = W'(NODE_CNT);

  state_e       state_q, state_d;
  logic [W-1:0] node_q, node_d;
  rec_t         rec_q, rec_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         grid_re_q, grid_re_d;
  logic         pos_re_q, pos_re_d;
  logic [W-1:0] pos_addr_q, pos_addr_d;
  logic [W-1:0] cell_cnt_q, cell_cnt_d;
  logic [W-1:0] mm_cnt_q, mm_cnt_d;

  logic         scan_clr, scan_inc, scan_last;
  logic [W-1:0] cur_x, cur_y, cur_addr;
  logic         err_c;

  grid_scan_counter #(.N(N)) u_scan (
    .clk    (clk),
    .reset  (reset),
    .clr    (scan_clr),
    .inc    (scan_inc),
    .x      (cur_x),
    .y      (cur_y),
    .addr   (cur_addr),
    .last_c (scan_last)
  );

  // Next state, counters and registered-output next values.
  always_comb begin
    state_d    = state_q;
    node_d     = node_q;
    rec_d      = rec_q;
    pos_addr_d = pos_addr_q;
    cell_cnt_d = cell_cnt_q;
    mm_cnt_d   = mm_cnt_q;
    scan_clr   = 1'b0;
    scan_inc   = 1'b0;
    err_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          scan_clr   = 1'b1;
          cell_cnt_d = '0;
          mm_cnt_d   = '0;
          state_d    = S_G_RD;
        end
      end
      S_G_RD:  state_d = S_G_CHK;
      S_G_CHK: begin
        node_d = grid_dout;
        if (grid_dout == EMPTY_CELL) begin
          state_d = S_NEXT;
        end else if (grid_dout >= ID_LIMIT) begin
          // Out-of-range id: never address the position RAMs with it.
          err_c   = 1'b1;
          state_d = S_EMIT;
        end else begin
          pos_addr_d = grid_dout;
          state_d    = S_P_RD;
        end
      end
      S_P_RD:  state_d = S_P_CHK;
      S_P_CHK: begin
        // Equality of W-bit patterns; an unplaced -1 can never match a cell.
        err_c   = (px_dout != cur_x) || (py_dout != cur_y);
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (valid_q && out_if.out_ready) begin
          cell_cnt_d = cell_cnt_q + W'(1);
          mm_cnt_d   = mm_cnt_q + W'(rec_q.err);
          state_d    = S_NEXT;
        end
      end
      S_NEXT: begin
        scan_inc = 1'b1;
        state_d  = scan_last ? S_DONE : S_G_RD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Record payload is captured on entry to EMIT and held through backpressure.
    if ((state_d == S_EMIT) && (state_q != S_EMIT)) begin
      rec_d = '{node: node_d, x: cur_x, y: cur_y, err: err_c};
    end

    valid_d   = (state_d == S_EMIT);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    grid_re_d = (state_d == S_G_RD);
    pos_re_d  = (state_d == S_P_RD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      node_q     <= '0;
      rec_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      grid_re_q  <= 1'b0;
      pos_re_q   <= 1'b0;
      pos_addr_q <= '0;
      cell_cnt_q <= '0;
      mm_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      node_q     <= node_d;
      rec_q      <= rec_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      grid_re_q  <= grid_re_d;
      pos_re_q   <= pos_re_d;
      pos_addr_q <= pos_addr_d;
      cell_cnt_q <= cell_cnt_d;
      mm_cnt_q   <= mm_cnt_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign grid_re        = grid_re_q;
  assign grid_addr      = cur_addr;
  assign px_re          = pos_re_q;
  assign py_re          = pos_re_q;
  assign px_addr        = pos_addr_q;
  assign py_addr        = pos_addr_q;
  assign cell_count     = cell_cnt_q;
  assign mismatch_count = mm_cnt_q;

  assign out_if.out_valid = valid_q;
  assign out_if.out_node  = rec_q.node;
  assign out_if.out_x     = rec_q.x;
  assign out_if.out_y     = rec_q.y;
  assign out_if.out_err   = rec_q.err;

endmodule

// File: tb/tb_placement_grid_reader.sv
// Randomized and directed bench for placement_grid_reader with N=3.
module tb_placement_grid_reader;
  import placement_pkg::*;

  localparam int unsigned TN    = 3;
  localparam int unsigned TNC   = 11;
  localparam int unsigned CELLS = TN * TN;

  logic         clk;
  logic         reset;
  logic         start;
  logic         busy, done;
  logic         grid_re, px_re, py_re;
  logic [W-1:0] grid_addr, px_addr, py_addr;
  logic [W-1:0] grid_dout, px_dout, py_dout;
  logic [W-1:0] cell_count, mismatch_count;

  placement_grid_reader_if out_if ();

  placement_grid_reader #(.N(TN), .NODE_CNT(TNC)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .grid_re        (grid_re),
    .grid_addr      (grid_addr),
    .grid_dout      (grid_dout),
    .px_re          (px_re),
    .px_addr        (px_addr),
    .px_dout        (px_dout),
    .py_re          (py_re),
    .py_addr        (py_addr),
    .py_dout        (py_dout),
    .out_if         (out_if),
    .cell_count     (cell_count),
    .mismatch_count (mismatch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories with synchronous read
  logic [W-1:0] grid_mem [CELLS];
  logic [W-1:0] px_mem   [16];
  logic [W-1:0] py_mem   [16];

  initial begin
    grid_dout = '0;
    px_dout   = '0;
    py_dout   = '0;
  end

  always @(posedge clk) begin
    if (grid_re && grid_addr < CELLS) grid_dout <= grid_mem[grid_addr[3:0]];
    if (px_re) px_dout <= px_mem[px_addr[3:0]];
    if (py_re) py_dout <= py_mem[py_addr[3:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: expected records and totals from the memory contents
  rec_t exp_q[$];
  int   exp_cells, exp_mm, exp_px, exp_lat;
  int   gidx, px_pulses, grid_pulses, done_pulses;

  task automatic build_model();
    int n_empty, n_bad, n_good;
    logic [W-1:0] v, cx, cy;
    logic e;
    exp_q.delete();
    exp_cells = 0; exp_mm = 0; exp_px = 0;
    n_empty = 0; n_bad = 0; n_good = 0;
    for (int a = 0; a < int'(CELLS); a++) begin
      cx = W'(a / int'(TN));
      cy = W'(a % int'(TN));
      v  = grid_mem[a];
      if (v == 32'hFFFF_FFFF) begin
        n_empty++;
      end else if (v >= TNC) begin
        exp_q.push_back('{node: v, x: cx, y: cy, err: 1'b1});
        n_bad++;
        exp_mm++;
      end else begin
        e = (px_mem[v[3:0]] != cx) || (py_mem[v[3:0]] != cy);
        exp_q.push_back('{node: v, x: cx, y: cy, err: e});
        n_good++;
        exp_px++;
        if (e) exp_mm++;
      end
    end
    exp_cells = n_bad + n_good;
    exp_lat   = 3 * n_empty + 4 * n_bad + 6 * n_good;
  endtask

  // Compare process: checks every meaningful output cycle against the model
  rec_t held, cur, ex;
  logic held_v = 1'b0;
  logic [W-1:0] en;

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      held_v = 1'b0;
    end else begin
      if (grid_re) begin
        grid_pulses++;
        chk("grid_addr", grid_addr, W'(gidx));
        gidx++;
      end
      if (px_re || py_re) begin
        px_pulses++;
        en = (exp_q.size() > 0) ? exp_q[0].node : '1;
        chk("py_re", W'(py_re), W'(px_re));
        chk("px_addr", px_addr, en);
        chk("py_addr", py_addr, en);
      end
      if (out_if.out_valid) begin
        cur = '{node: out_if.out_node, x: out_if.out_x, y: out_if.out_y, err: out_if.out_err};
        if (held_v) chk("held_record", cur, held);
        if (out_if.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_record got node %0d x %0d y %0d expected none", cur.node, cur.x, cur.y);
          end else begin
            ex = exp_q.pop_front();
            chk("rec_node", cur.node, ex.node);
            chk("rec_x", cur.x, ex.x);
            chk("rec_y", cur.y, ex.y);
            chk("rec_err", W'(cur.err), W'(ex.err));
          end
          held_v = 1'b0;
        end else begin
          held   = cur;
          held_v = 1'b1;
        end
      end else begin
        held_v = 1'b0;
      end
      if (done) begin
        done_pulses++;
        chk("done_cell_count", cell_count, W'(exp_cells));
        chk("done_mismatch_count", mismatch_count, W'(exp_mm));
        chk("records_left", W'(exp_q.size()), '0);
        chk("pos_read_pulses", W'(px_pulses), W'(exp_px));
        chk("grid_read_pulses", W'(grid_pulses), W'(CELLS));
      end
    end
  end

  task automatic clear_mem();
    for (int a = 0; a < int'(CELLS); a++) grid_mem[a] = '1;
    for (int i = 0; i < 16; i++) begin
      px_mem[i] = '1;
      py_mem[i] = '1;
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: stall first record, plus stray start
  task automatic run_scan(input int mode, output int lat);
    int stall;
    int d0;
    build_model();
    gidx = 0; px_pulses = 0; grid_pulses = 0;
    d0 = done_pulses;
    @(negedge clk);
    start = 1'b1;
    out_if.out_ready = (mode == 0);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    stall = 0;
    while (!done && lat < 3000) begin
      case (mode)
        0: out_if.out_ready = 1'b1;
        1: out_if.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_if.out_valid && stall < 11) stall++;
          out_if.out_ready = (stall >= 11);
        end
      endcase
      start = (mode == 2 && lat == 5);
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout got %0d cycles expected done", lat);
    end else if (mode == 0) begin
      chk("scan_latency", W'(lat), W'(exp_lat));
    end
    // start coinciding with done must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_if.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("busy_after_done", W'(busy), '0);
    end
    chk("done_pulse_count", W'(done_pulses - d0), W'(1));
  endtask

  int lat;
  int d_before;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    out_if.out_ready = 1'b0;
    clear_mem();
    build_model();
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_grid_re", W'(grid_re), '0);
    chk("rst_grid_addr", grid_addr, '0);
    chk("rst_px_re", W'(px_re), '0);
    chk("rst_out_valid", W'(out_if.out_valid), '0);
    chk("rst_cell_count", cell_count, '0);
    chk("rst_mismatch_count", mismatch_count, '0);
    reset = 1'b1;
    @(negedge clk);

    // Empty grid: 9 cells x 3 cycles
    clear_mem();
    run_scan(0, lat);
    chk("empty_latency", W'(lat), W'(27));
    chk("empty_cell_count", cell_count, W'(0));

    // Reset mid-scan
    build_model();
    gidx = 0;
    d_before = done_pulses;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midscan_busy_before", W'(busy), W'(1));
    reset = 1'b0;
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_grid_re", W'(grid_re), '0);
    chk("abort_grid_addr", grid_addr, '0);
    chk("abort_px_re", W'(px_re), '0);
    chk("abort_py_addr", py_addr, '0);
    chk("abort_out_valid", W'(out_if.out_valid), '0);
    chk("abort_out_node", out_if.out_node, '0);
    chk("abort_cell_count", cell_count, '0);
    chk("abort_mismatch_count", mismatch_count, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", W'(done_pulses - d_before), '0);
    chk("abort_idle", W'(busy), '0);

    // Consistent placement
    clear_mem();
    grid_mem[4] = 2; px_mem[2] = 1; py_mem[2] = 1;
    run_scan(0, lat);
    chk("consistent_latency", W'(lat), W'(30));
    chk("consistent_cells", cell_count, W'(1));
    chk("consistent_mm", mismatch_count, W'(0));

    // Inconsistent placement
    clear_mem();
    grid_mem[0] = 5; grid_mem[8] = 3;
    px_mem[5] = 0; py_mem[5] = 1; px_mem[3] = 2; py_mem[3] = 2;
    run_scan(0, lat);
    chk("incons_cells", cell_count, W'(2));
    chk("incons_mm", mismatch_count, W'(1));

    // Bad node id: no position reads
    clear_mem();
    grid_mem[1] = 11;
    run_scan(0, lat);
    chk("badid_latency", W'(lat), W'(28));
    chk("badid_pos_reads", W'(px_pulses), W'(0));
    chk("badid_mm", mismatch_count, W'(1));

    // Backpressure with a stray start mid-scan
    clear_mem();
    grid_mem[0] = 5; grid_mem[8] = 3;
    px_mem[5] = 0; py_mem[5] = 1; px_mem[3] = 2; py_mem[3] = 2;
    run_scan(2, lat);
    chk("bp_cells", cell_count, W'(2));
    chk("bp_mm", mismatch_count, W'(1));

    // Randomized grids and backpressure
    for (int t = 0; t < 8; t++) begin
      clear_mem();
      for (int a = 0; a < int'(CELLS); a++) begin
        if ($urandom_range(0, 2) != 0) begin
          logic [W-1:0] v;
          v = W'($urandom_range(0, 13));
          grid_mem[a] = v;
          if (v < TNC && $urandom_range(0, 1) == 1) begin
            px_mem[v[3:0]] = W'(a / int'(TN));
            py_mem[v[3:0]] = W'(a % int'(TN));
          end else if (v < TNC) begin
            px_mem[v[3:0]] = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom_range(0, 2));
            py_mem[v[3:0]] = W'($urandom_range(0, 2));
          end
        end
      end
      run_scan((t % 3 == 0) ? 0 : 1, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
